// File: rtl/fifo_memoria.sv
// fifo_memoria: synchronous FIFO over a dual-pointer register-file memory.
// Provides push/pop flow control, full/empty and programmable almost flags,
// an occupancy count and a sticky overflow/underflow error bit.
// Build option: define FIFO_FWFT_EN for first-word-fall-through reads;
// left undefined, data_out/valid_out are registered (one-cycle read latency).
//
// Handshake: push is taken when (push && (!full || pop)); pop is taken when
// (pop && !empty). A push arriving with pop while full is taken because the
// pop frees the slot in the same edge; a pop arriving with push while empty is
// ignored (and not an underflow) because there is no stored word to read yet.
module fifo_memoria #(
  parameter int BUS_SIZE        = 4,
  parameter int ADDR_WIDTH      = 4,
  parameter int ALMOST_FULL_TH  = 12,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  input  logic [BUS_SIZE-1:0]   data_in,
  output logic [BUS_SIZE-1:0]   data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   fifo_count
);

  localparam int MEM_LENGTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(MEM_LENGTH);
  localparam logic [ADDR_WIDTH:0]   AF_CNT   = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0]   AE_CNT   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [BUS_SIZE-1:0]   mem_q [MEM_LENGTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  error_q, error_d;
  logic                  push_acc, pop_acc, overflow, underflow;

  // Flags are decoded from the registered count only.
  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign error        = error_q;
  assign fifo_count   = count_q;

  assign push_acc  = push && (!full || pop);
  assign pop_acc   = pop && !empty;
  assign overflow  = push && full && !pop;
  assign underflow = pop && empty && !push;

  // Next-state for pointers, occupancy and the sticky error bit.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    error_d  = error_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (overflow || underflow) error_d = 1'b1;
  end

  // Control state register; cleared asynchronously.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  // Storage array; intentionally not reset, contents valid only once written.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  // Head word is shown directly; a pop consumes what is currently displayed.
  assign data_out  = mem_q[rd_ptr_q];
  assign valid_out = !empty;
`else
  logic [BUS_SIZE-1:0] dout_q, dout_d;
  logic                vld_q, vld_d;

  // Read port: capture the head word on an accepted pop, otherwise hold data.
  always_comb begin
    dout_d = dout_q;
    vld_d  = pop_acc;
    if (pop_acc) dout_d = mem_q[rd_ptr_q];
  end

  // Registered read outputs; cleared asynchronously.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= vld_d;
    end
  end

  assign data_out  = dout_q;
  assign valid_out = vld_q;
`endif

endmodule

// File: tb/tb_fifo_memoria.sv
// Testbench for fifo_memoria: randomized and directed traffic checked against
// a queue-based reference model, with a scoreboard of expected read words.
module tb_fifo_memoria;

  localparam int W = 4;
  localparam int DEPTH = 16;
  localparam int AF_TH = 12;
  localparam int AE_TH = 2;

  logic         clk = 1'b0;
  logic         reset_L = 1'b0;
  logic         push = 1'b0;
  logic         pop = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         full, empty, almost_full, almost_empty, error;
  logic [4:0]   fifo_count;

  fifo_memoria #(
    .BUS_SIZE(W), .ADDR_WIDTH(4), .ALMOST_FULL_TH(AF_TH), .ALMOST_EMPTY_TH(AE_TH)
  ) dut (
    .clk(clk), .reset_L(reset_L), .push(push), .pop(pop), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .error(error),
    .fifo_count(fifo_count)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model: contents as a plain queue, sticky error, last-cycle read.
  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_q[$];
  bit           model_err = 1'b0;
  bit           model_vld = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances right after the active edge.
  task automatic step(input bit p, input bit q, input logic [W-1:0] d);
    bit full_m, empty_m, pa, qa;
    @(negedge clk); #1;
    push = p; pop = q; data_in = d;
    @(posedge clk); #1;
    full_m  = (model_q.size() == DEPTH);
    empty_m = (model_q.size() == 0);
    qa = q && !empty_m;
    pa = p && (!full_m || q);
    if (p && full_m && !q) model_err = 1'b1;
    if (q && empty_m && !p) model_err = 1'b1;
    if (qa) begin
`ifdef FIFO_FWFT_EN
      void'(model_q.pop_front());
`else
      exp_q.push_back(model_q.pop_front());
`endif
    end
    if (pa) model_q.push_back(d);
    model_vld = qa;
    push = 1'b0; pop = 1'b0;
  endtask

  // Reset: outputs must clear immediately, then hold for 2 cycles.
  task automatic do_reset();
    @(negedge clk); #1;
    reset_L = 1'b0; push = 1'b0; pop = 1'b0;
    model_q.delete(); exp_q.delete();
    model_err = 1'b0; model_vld = 1'b0;
    #1;
    check("rst_count", fifo_count, 0);
    check("rst_empty", empty, 1);
    check("rst_almost_empty", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_almost_full", almost_full, 0);
    check("rst_error", error, 0);
    check("rst_valid_out", valid_out, 0);
`ifndef FIFO_FWFT_EN
    check("rst_data_out", data_out, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    reset_L = 1'b1;
  endtask

  // Monitor / scoreboard: flags every cycle, read data whenever presented.
  always @(negedge clk) begin
    if (reset_L) begin
      check("fifo_count", fifo_count, model_q.size());
      check("full", full, int'(model_q.size() == DEPTH));
      check("empty", empty, int'(model_q.size() == 0));
      check("almost_full", almost_full, int'(model_q.size() >= AF_TH));
      check("almost_empty", almost_empty, int'(model_q.size() <= AE_TH));
      check("error", error, model_err);
`ifdef FIFO_FWFT_EN
      check("valid_out", valid_out, int'(model_q.size() != 0));
      if (valid_out && model_q.size() != 0) check("data_out", data_out, model_q[0]);
`else
      check("valid_out", valid_out, model_vld);
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL data_out: got %0d with valid_out but no word expected at %0t",
                   data_out, $time);
        end else begin
          check("data_out", data_out, exp_q.pop_front());
        end
      end
`endif
    end
  end

  initial begin
    // Reset then idle
    do_reset();
    step(0, 0, 0);
    step(0, 0, 0);

    // Fill with 0x0..0xF, then an overflow push of 0xA
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, W'(i));
      if (i == AF_TH - 2) check("af_before_12th", almost_full, 0);
      if (i == AF_TH - 1) check("af_after_12th", almost_full, 1);
      if (i == DEPTH - 2) check("full_before_16th", full, 0);
    end
    check("full_after_16th", full, 1);
    check("fill_count", fifo_count, 16);
    step(1, 0, 4'hA);
    check("overflow_error", error, 1);
    check("overflow_count", fifo_count, 16);

    // Drain: scoreboard expects 0x0..0xF in order
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 0);
      if (i == DEPTH - 3) check("ae_at_count2", almost_empty, 1);
    end
    check("empty_after_drain", empty, 1);
    step(0, 0, 0);

    // Simultaneous push/pop while full, then while empty
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 0, W'($urandom_range(0, 15)));
    step(1, 1, 4'h5);
    check("full_pp_count", fifo_count, 16);
    check("full_pp_error", error, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0);
    step(0, 0, 0);
    step(1, 1, 4'h3);
    check("empty_pp_count", fifo_count, 1);
    check("empty_pp_error", error, 0);
    step(0, 0, 0);
    step(0, 1, 0);

    // Wrap-around: random interleaving keeping occupancy in 3..10
    while (model_q.size() < 5) step(1, 0, W'($urandom_range(0, 15)));
    for (int i = 0; i < 40; i++) begin
      bit p, q;
      p = 1'($urandom_range(0, 1));
      q = 1'($urandom_range(0, 1));
      if (model_q.size() >= 10) p = 1'b0;
      if (model_q.size() <= 3) q = 1'b0;
      step(p, q, W'($urandom_range(0, 15)));
    end

    // Underflow
    while (model_q.size() > 0) step(0, 1, 0);
    step(0, 1, 0);
    check("underflow_error", error, 1);
    step(0, 0, 0);

    // Mid-operation reset with 7 words stored, then push 0x9 / pop
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 0, W'($urandom_range(0, 15)));
    check("pre_reset_count", fifo_count, 7);
    do_reset();
    step(1, 0, 4'h9);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_memoria.md
# fifo_memoria

Parametrised synchronous FIFO built on a dual-pointer register-file memory of `MEM_LENGTH` words. It adds push/pop flow control, full/empty and programmable almost-full/almost-empty flags, an occupancy count and sticky overflow/underflow error reporting. It is the buffering stage that producers and consumers in the datapath use to decouple bursty traffic.

## Interface
- `BUS_SIZE`, 4: data word width in bits.
- `ADDR_WIDTH`, 4: pointer width; depth `MEM_LENGTH = 1 << ADDR_WIDTH` (derived, not overridable).
- `ALMOST_FULL_TH`, 12: `almost_full` asserts when count ≥ this value; legal range 1..MEM_LENGTH.
- `ALMOST_EMPTY_TH`, 2: `almost_empty` asserts when count ≤ this value; legal range 0..MEM_LENGTH-1.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_L` input 1: asynchronous, active-low reset.
- `push` input 1: write request for `data_in`.
- `pop` input 1: read request for the head word.
- `data_in` input BUS_SIZE: write data.
- `data_out` output BUS_SIZE: read data.
- `valid_out` output 1: `data_out` holds a popped word.
- `full` output 1: count == MEM_LENGTH.
- `empty` output 1: count == 0.
- `almost_full` output 1: count ≥ ALMOST_FULL_TH.
- `almost_empty` output 1: count ≤ ALMOST_EMPTY_TH.
- `error` output 1: sticky overflow/underflow indicator.
- `fifo_count` output ADDR_WIDTH+1: current occupancy, 0..MEM_LENGTH.

## Operation
- Write pointer, read pointer: ADDR_WIDTH bits, wrap modulo MEM_LENGTH naturally. Count register is ADDR_WIDTH+1 bits, so full and empty are unambiguous.
- Push accepted when `push && (!full || pop)`: write `data_in` to mem[wr_ptr], then wr_ptr+1.
- Pop accepted when `pop && !empty`: read mem[rd_ptr], then rd_ptr+1.
- Count: +1 on accepted push only; −1 on accepted pop only; unchanged when both or neither are accepted.
- Push while full with pop: both accepted, count stays MEM_LENGTH.
- Push and pop while empty: push accepted, pop ignored, no underflow flagged, count becomes 1.
- Overflow: push && full && !pop. Word is dropped; pointers and count are unchanged; `error` is set.
- Underflow: pop && empty. Nothing is read; `valid_out` = 0; `error` is set.
- `error` stays 1 until `reset_L` is asserted.
- All flags are decoded from the registered count.
- Memory array is not reset; its contents are undefined until written.

## Timing
- Reset (asynchronous, immediate):
  - pointers and count = 0
  - `data_out` = 0, `valid_out` = 0
  - `empty` = 1, `almost_empty` = 1
  - `full` = 0, `almost_full` = 0, `error` = 0
- Reset asserted mid-operation discards all stored words; the first push after reset release is stored at address 0.
- Flags and `fifo_count` change on the clock edge that accepts the push/pop, so they are visible in the cycle after the request.
- Default read mode: `data_out` and `valid_out` are registered. A pop accepted at edge N gives the word and `valid_out` = 1 after edge N. `valid_out` returns to 0 at the next edge without an accepted pop. `data_out` holds its last value when no pop is accepted.
- Write-to-read latency: a word pushed at edge N can be popped at edge N+1, at the earliest, and appears on `data_out` after edge N+1.
- With MEM_LENGTH entries, the push/pop throughput is one word per cycle.

## Configuration
- `FIFO_FWFT_EN` defined: first-word-fall-through mode.
  - `data_out` = mem[rd_ptr] combinationally.
  - `valid_out` = !empty.
  - A pop at edge N consumes the displayed word; the next word (or invalid) shows after edge N.
- `FIFO_FWFT_EN` undefined: registered one-cycle read latency, as described in Timing.
- Flag, count and error behaviour are identical in both modes.

## Test plan
- Reset then idle: `reset_L` = 0 for 2 cycles, release. Required: `empty` = 1, `almost_empty` = 1, `fifo_count` = 0, `valid_out` = 0, `error` = 0.
- Fill: push 0x0..0xF on 16 consecutive cycles. Required:
  - `almost_full` rises after the 12th push.
  - `full` rises after the 16th push.
  - `fifo_count` = 16.
  - A 17th push of 0xA sets `error` = 1 with count still 16.
- Drain: from full, pop 16 cycles. Required:
  - `data_out` sequence is 0x0..0xF, each with `valid_out` = 1 one cycle after its pop.
  - `almost_empty` rises when count = 2.
  - `empty` rises after the 16th pop.
- Simultaneous push/pop when full: push 0x5 with pop. Required: pop returns the head word, count stays 16, `error` = 0. When empty, push+pop: count = 1, no `valid_out`, `error` = 0.
- Wrap-around: 40 cycles of interleaved push/pop with random data, keeping count between 3 and 10. Required: output order matches a reference queue with no loss or duplication.
- Underflow and mid-operation reset: pop when empty sets `error` = 1. Asserting `reset_L` with count = 7 clears all state at once; a subsequent push of 0x9 then pop returns 0x9.
